// File: rtl/ula_issue_if.sv
// Handshake and operand bundle between the decode/register-read stage, the issue buffer and the ULA.
interface ula_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic        in_funct7b5;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_aluop;
  logic [3:0]  out_ctrl;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic        illegal;
  logic [7:0]  illegal_cnt;

  modport master (
    output in_valid, in_opcode, in_funct3, in_funct7b5, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_aluop, out_ctrl, out_a, out_b, illegal, illegal_cnt
  );

  modport slave (
    input  in_valid, in_opcode, in_funct3, in_funct7b5, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_aluop, out_ctrl, out_a, out_b, illegal, illegal_cnt
  );
endinterface

// File: rtl/ula_issue.sv
// ULA issue stage: decodes instructions into aluop/ctrl/operands and buffers them in a 2-entry FIFO.
// Define ULA_ISSUE_IMM_EN to decode I-type arithmetic (opcode 0010011); otherwise it is illegal.
module ula_issue (
  input logic       clk,
  input logic       rst_n,
  ula_issue_if.slave bus
);

  logic [1:0]  aluop_q [2];
  logic [3:0]  ctrl_q  [2];
  logic [31:0] a_q     [2];
  logic [31:0] b_q     [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic        rdy_en;
  logic        illegal_q;
  logic [7:0]  illegal_cnt_q;

  logic        dec_legal;
  logic [1:0]  dec_aluop;
  logic [3:0]  dec_ctrl;
  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic        accept;
  logic        push;
  logic        pop;
  logic        ill_acc;

  always_comb begin
    dec_legal = 1'b0;
    dec_aluop = 2'b00;
    dec_ctrl  = 4'b0000;
    dec_a     = bus.in_rs1;
    dec_b     = bus.in_rs2;
    case (bus.in_opcode)
      7'b0000011, 7'b0100011: begin
        dec_legal = 1'b1;
        dec_aluop = 2'b00;
        dec_ctrl  = 4'b0010;
        dec_b     = bus.in_imm;
      end
      7'b1100011: begin
        dec_legal = 1'b1;
        dec_aluop = 2'b01;
        dec_ctrl  = 4'b0110;
      end
      7'b0110011: begin
        dec_aluop = 2'b10;
        case ({bus.in_funct3, bus.in_funct7b5})
          4'b0000:          begin dec_legal = 1'b1; dec_ctrl = 4'b0010; end
          4'b0001:          begin dec_legal = 1'b1; dec_ctrl = 4'b0110; end
          4'b1110, 4'b1111: begin dec_legal = 1'b1; dec_ctrl = 4'b0000; end
          4'b1100, 4'b1101: begin dec_legal = 1'b1; dec_ctrl = 4'b0001; end
          4'b0100:          begin dec_legal = 1'b1; dec_ctrl = 4'b0111; end
          default:          dec_legal = 1'b0;
        endcase
      end
`ifdef ULA_ISSUE_IMM_EN
      7'b0010011: begin
        // no subtract-immediate exists, so funct7b5 plays no part here
        dec_aluop = 2'b10;
        dec_b     = bus.in_imm;
        case (bus.in_funct3)
          3'b000:  begin dec_legal = 1'b1; dec_ctrl = 4'b0010; end
          3'b111:  begin dec_legal = 1'b1; dec_ctrl = 4'b0000; end
          3'b110:  begin dec_legal = 1'b1; dec_ctrl = 4'b0001; end
          3'b010:  begin dec_legal = 1'b1; dec_ctrl = 4'b0111; end
          default: dec_legal = 1'b0;
        endcase
      end
`endif
      default: dec_legal = 1'b0;
    endcase
  end

  // full blocks acceptance even when a pop happens on the same edge
  assign bus.in_ready  = rdy_en && (count != 2'd2);
  assign bus.out_valid = (count != 2'd0);
  assign accept  = bus.in_valid && bus.in_ready;
  assign push    = accept && dec_legal;
  assign ill_acc = accept && !dec_legal;
  assign pop     = bus.out_valid && bus.out_ready;

  assign bus.out_aluop   = aluop_q[rd_ptr];
  assign bus.out_ctrl    = ctrl_q[rd_ptr];
  assign bus.out_a       = a_q[rd_ptr];
  assign bus.out_b       = b_q[rd_ptr];
  assign bus.illegal     = illegal_q;
  assign bus.illegal_cnt = illegal_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        aluop_q[i] <= 2'b00;
        ctrl_q[i]  <= 4'b0000;
        a_q[i]     <= 32'd0;
        b_q[i]     <= 32'd0;
      end
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      count         <= 2'd0;
      rdy_en        <= 1'b0;
      illegal_q     <= 1'b0;
      illegal_cnt_q <= 8'd0;
    end else begin
      rdy_en    <= 1'b1;
      illegal_q <= ill_acc;
      if (ill_acc && (illegal_cnt_q != 8'hFF)) begin
        illegal_cnt_q <= illegal_cnt_q + 8'd1;
      end
      if (push) begin
        aluop_q[wr_ptr] <= dec_aluop;
        ctrl_q[wr_ptr]  <= dec_ctrl;
        a_q[wr_ptr]     <= dec_a;
        b_q[wr_ptr]     <= dec_b;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_issue.sv
// Directed bench for ula_issue: decode table, FIFO backpressure/order, illegal counting, reset.
module tb_ula_issue;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  int   exp_cnt;
  int   pulses;
  int   ov_seen;

  ula_issue_if bus ();

  ula_issue dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm);
    bus.in_valid    = v;
    bus.in_opcode   = op;
    bus.in_funct3   = f3;
    bus.in_funct7b5 = f7;
    bus.in_rs1      = rs1;
    bus.in_rs2      = rs2;
    bus.in_imm      = imm;
  endtask

  // R-type table: funct3, funct7b5, expected ctrl, legal
  logic [2:0] rt_f3  [8] = '{3'b000, 3'b000, 3'b111, 3'b110, 3'b010, 3'b001, 3'b010, 3'b110};
  logic       rt_f7  [8] = '{1'b0,   1'b1,   1'b1,   1'b0,   1'b0,   1'b0,   1'b1,   1'b1};
  logic [3:0] rt_ctl [8] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b0000, 4'b0000, 4'b0001};
  logic       rt_ok  [8] = '{1'b1,   1'b1,   1'b1,   1'b1,   1'b1,   1'b0,   1'b0,   1'b1};

  initial begin
    n_cmp = 0;
    n_err = 0;
    exp_cnt = 0;
    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 7'd0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0);
    #3;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_out_a", bus.out_a, 32'd0);
    chk("rst_out_ctrl", {28'd0, bus.out_ctrl}, 32'd0);
    chk("rst_illegal_cnt", {24'd0, bus.illegal_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("ready_after_release", {31'd0, bus.in_ready}, 32'd1);

    // R-type add 5 + 3
    bus.out_ready = 1'b1;
    drive(1'b1, 7'b0110011, 3'b000, 1'b0, 32'd5, 32'd3, 32'hDEAD);
    step();
    bus.in_valid = 1'b0;
    chk("add_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("add_aluop", {30'd0, bus.out_aluop}, 32'd2);
    chk("add_ctrl", {28'd0, bus.out_ctrl}, 32'd2);
    chk("add_a", bus.out_a, 32'd5);
    chk("add_b", bus.out_b, 32'd3);
    step();
    chk("add_popped", {31'd0, bus.out_valid}, 32'd0);

    // load uses imm as b
    drive(1'b1, 7'b0000011, 3'b010, 1'b0, 32'h100, 32'h55, 32'h10);
    step();
    bus.in_valid = 1'b0;
    chk("ld_aluop", {30'd0, bus.out_aluop}, 32'd0);
    chk("ld_ctrl", {28'd0, bus.out_ctrl}, 32'd2);
    chk("ld_a", bus.out_a, 32'h100);
    chk("ld_b", bus.out_b, 32'h10);
    step();

    // store
    drive(1'b1, 7'b0100011, 3'b010, 1'b0, 32'h200, 32'h66, 32'h8);
    step();
    bus.in_valid = 1'b0;
    chk("st_aluop", {30'd0, bus.out_aluop}, 32'd0);
    chk("st_b", bus.out_b, 32'h8);
    step();

    // branch subtracts rs2
    drive(1'b1, 7'b1100011, 3'b000, 1'b0, 32'd7, 32'd7, 32'h99);
    step();
    bus.in_valid = 1'b0;
    chk("br_aluop", {30'd0, bus.out_aluop}, 32'd1);
    chk("br_ctrl", {28'd0, bus.out_ctrl}, 32'd6);
    chk("br_a", bus.out_a, 32'd7);
    chk("br_b", bus.out_b, 32'd7);
    step();

    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 7'b0110011, rt_f3[i], rt_f7[i], 32'd100 + i, 32'd200 + i, 32'd0);
      step();
      bus.in_valid = 1'b0;
      if (rt_ok[i]) begin
        chk($sformatf("rt%0d_valid", i), {31'd0, bus.out_valid}, 32'd1);
        chk($sformatf("rt%0d_ctrl", i), {28'd0, bus.out_ctrl}, {28'd0, rt_ctl[i]});
        chk($sformatf("rt%0d_b", i), bus.out_b, 32'd200 + i);
        chk($sformatf("rt%0d_illegal", i), {31'd0, bus.illegal}, 32'd0);
      end else begin
        exp_cnt++;
        chk($sformatf("rt%0d_illegal", i), {31'd0, bus.illegal}, 32'd1);
        chk($sformatf("rt%0d_not_issued", i), {31'd0, bus.out_valid}, 32'd0);
      end
      step();
      chk($sformatf("rt%0d_pulse_end", i), {31'd0, bus.illegal}, 32'd0);
    end
    chk("cnt_after_rtype", {24'd0, bus.illegal_cnt}, exp_cnt);

    // backpressure: two fill the FIFO, third waits
    bus.out_ready = 1'b0;
    drive(1'b1, 7'b0110011, 3'b000, 1'b0, 32'd1, 32'd11, 32'd0);
    step();
    chk("bp_ready_1", {31'd0, bus.in_ready}, 32'd1);
    drive(1'b1, 7'b0110011, 3'b000, 1'b1, 32'd2, 32'd22, 32'd0);
    step();
    chk("bp_ready_2", {31'd0, bus.in_ready}, 32'd0);
    drive(1'b1, 7'b0110011, 3'b111, 1'b0, 32'd3, 32'd33, 32'd0);
    step();
    chk("bp_held_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("bp_head_stable_a", bus.out_a, 32'd1);
    chk("bp_head_stable_ctrl", {28'd0, bus.out_ctrl}, 32'd2);
    bus.out_ready = 1'b1;
    step();
    chk("bp_second_a", bus.out_a, 32'd2);
    chk("bp_second_ctrl", {28'd0, bus.out_ctrl}, 32'd6);
    chk("bp_ready_after_pop", {31'd0, bus.in_ready}, 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("bp_third_a", bus.out_a, 32'd3);
    chk("bp_third_ctrl", {28'd0, bus.out_ctrl}, 32'd0);
    chk("bp_third_valid", {31'd0, bus.out_valid}, 32'd1);
    step();
    chk("bp_drained", {31'd0, bus.out_valid}, 32'd0);

    // I-type add with all-ones immediate
    drive(1'b1, 7'b0010011, 3'b000, 1'b0, 32'd4, 32'h1234, 32'hFFFF_FFFF);
    step();
    bus.in_valid = 1'b0;
`ifdef ULA_ISSUE_IMM_EN
    chk("imm_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("imm_aluop", {30'd0, bus.out_aluop}, 32'd2);
    chk("imm_ctrl", {28'd0, bus.out_ctrl}, 32'd2);
    chk("imm_b", bus.out_b, 32'hFFFF_FFFF);
`else
    exp_cnt++;
    chk("imm_illegal", {31'd0, bus.illegal}, 32'd1);
    chk("imm_not_issued", {31'd0, bus.out_valid}, 32'd0);
`endif
    step();
    chk("cnt_after_imm", {24'd0, bus.illegal_cnt}, exp_cnt);

    // 300 back-to-back illegal opcodes saturate the counter
    pulses = 0;
    ov_seen = 0;
    drive(1'b1, 7'b1111111, 3'b000, 1'b0, 32'd0, 32'd0, 32'd0);
    for (int i = 0; i < 300; i++) begin
      step();
      if (bus.illegal) pulses++;
      if (bus.out_valid) ov_seen++;
    end
    bus.in_valid = 1'b0;
    step();
    chk("ill_pulses", pulses, 32'd300);
    chk("ill_out_valid_seen", ov_seen, 32'd0);
    chk("ill_pulse_end", {31'd0, bus.illegal}, 32'd0);
    chk("ill_cnt_sat", {24'd0, bus.illegal_cnt}, 32'd255);

    // mid-cycle reset with two entries queued
    bus.out_ready = 1'b0;
    drive(1'b1, 7'b0110011, 3'b000, 1'b0, 32'd9, 32'd8, 32'd0);
    step();
    drive(1'b1, 7'b0110011, 3'b110, 1'b0, 32'd10, 32'd12, 32'd0);
    step();
    bus.in_valid = 1'b0;
    chk("mr_full", {31'd0, bus.in_ready}, 32'd0);
    chk("mr_valid_before", {31'd0, bus.out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_valid_now", {31'd0, bus.out_valid}, 32'd0);
    chk("mr_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("mr_out_a", bus.out_a, 32'd0);
    chk("mr_out_b", bus.out_b, 32'd0);
    chk("mr_cnt", {24'd0, bus.illegal_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    ov_seen = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.out_valid) ov_seen++;
    end
    chk("mr_nothing_issued", ov_seen, 32'd0);
    chk("mr_ready_again", {31'd0, bus.in_ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
